axis_diff_scheduler: RTL

Round-robin scheduler that time-shares one first-difference datapath, y[n] = x[n] - x[n-1], across N_CH independent ECG sample streams. Each channel keeps its own x[n-1] history register, so one subtractor serves every lead. The block sits between the per-lead ADC/decimation stages and the downstream QRS-detection pipeline. It emits one tagged result stream with full AXI-Stream backpressure.

---
 rtl/axis_diff_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/axis_diff_scheduler.sv
// axis_diff_scheduler
//   Time-shares a single first-difference datapath, y[n] = x[n] - x[n-1],
//   across N_CH independent signed sample streams. Each channel keeps its
//   own x[n-1] history. Results leave on one AXI-Stream output, tagged with
//   the source channel index.
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   s_axis_tvalid   [N_CH]         per-channel input valid
//   s_axis_tdata    [N_CH*DATA_W]  channel i at [i*DATA_W +: DATA_W], signed
//   s_axis_tready   [N_CH]         one-hot grant (or zero) for this cycle
//   clr_hist        [N_CH]         synchronous per-channel history clear
//   m_axis_tvalid                  result valid
//   m_axis_tdata    [DATA_W]       signed difference for the tagged channel
//   m_axis_tuser    [CH_W]         channel index of m_axis_tdata
//   m_axis_tready                  downstream ready
module axis_diff_scheduler #(
  parameter  int unsigned N_CH   = 4,
  parameter  int unsigned DATA_W = 16,
  localparam int unsigned CH_W   = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          s_axis_tvalid,
  input  logic [N_CH*DATA_W-1:0]   s_axis_tdata,
  output logic [N_CH-1:0]          s_axis_tready,
  input  logic [N_CH-1:0]          clr_hist,
  output logic                     m_axis_tvalid,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic [CH_W-1:0]          m_axis_tuser,
  input  logic                     m_axis_tready
);

  // (base + off) mod N_CH; correct for non-power-of-two channel counts.
  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return CH_W'(s);
  endfunction

  logic [DATA_W-1:0] hist_q [N_CH];
  logic [DATA_W-1:0] hist_d [N_CH];
  logic [DATA_W-1:0] s_data [N_CH];
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CH_W-1:0]   m_tag_q, m_tag_d;

  logic              slot_free;
  logic              found;
  logic              accept;
  logic [CH_W-1:0]   gnt_idx;
  logic [N_CH-1:0]   gnt;
  logic [DATA_W-1:0] prev;

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      s_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting at ptr_q; first valid channel wins.
  always_comb begin
    slot_free = !m_valid_q || m_axis_tready;
    found     = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (!found && s_axis_tvalid[wrap_add(ptr_q, k)]) begin
        found   = 1'b1;
        gnt_idx = wrap_add(ptr_q, k);
      end
    end
    gnt = '0;
    // rst_n gating keeps the grant low for the whole reset interval.
    if (slot_free && found && rst_n) gnt[gnt_idx] = 1'b1;
    accept = |gnt;
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_tag_d   = m_tag_q;
    ptr_d     = ptr_q;
    hist_d    = hist_q;
    prev      = clr_hist[gnt_idx] ? '0 : hist_q[gnt_idx];

    if (slot_free) m_valid_d = accept;
    if (accept) begin
      m_data_d = s_data[gnt_idx] - prev;
      m_tag_d  = gnt_idx;
      ptr_d    = wrap_add(gnt_idx, 1);
    end

    // An accepted sample overrides a coincident clear on the same channel.
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (accept && (gnt_idx == CH_W'(i))) begin
        hist_d[i] = s_data[i];
      end else if (clr_hist[i]) begin
        hist_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_tag_q   <= '0;
      ptr_q     <= '0;
      for (int unsigned i = 0; i < N_CH; i++) hist_q[i] <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_tag_q   <= m_tag_d;
      ptr_q     <= ptr_d;
      for (int unsigned i = 0; i < N_CH; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign s_axis_tready = gnt;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_tag_q;

endmodule
